// File: rtl/traffic_pkg.sv
// Shared light codes and pedestrian FSM states for traffic_light and ped_signal_ctrl.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_GREEN   = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b10;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2
  } ped_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button followed by a one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: grants WALK on vehicle red entry, then a timed flashing CLEAR.
// Optional countdown display built when PED_COUNTDOWN_EN is defined.
module ped_signal_ctrl
  import traffic_pkg::*;
#(
  parameter int WALK_CYCLES  = 6,
  parameter int CLEAR_CYCLES = 4,
  parameter int FLASH_DIV    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       flash,
  output logic [3:0] countdown,
  output logic       req_pending
);

  localparam int MAXC = (WALK_CYCLES > CLEAR_CYCLES) ? WALK_CYCLES : CLEAR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int FW   = $clog2(FLASH_DIV + 1);
  localparam logic [CW-1:0] WALK_LAST  = CW'(WALK_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [FW-1:0] FDIV_LAST  = FW'(FLASH_DIV - 1);

  ped_state_t    state;
  logic [1:0]    light_q;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fcnt;
  logic          btn_pulse;
  logic          is_red, red_entry, grant, walk_done, to_stop;

  btn_sync_edge u_btn (
    .clk   (clk),
    .reset (reset),
    .btn   (ped_btn),
    .pulse (btn_pulse)
  );

  assign is_red    = (light == LIGHT_RED);
  assign red_entry = is_red && (light_q != LIGHT_RED);
  assign grant     = (state == STOP) && red_entry && req_pending;
  assign walk_done = (state == WALK) && (cnt == WALK_LAST);
  // Losing red always wins over a counter that happens to expire on the same edge.
  assign to_stop   = (state != STOP) &&
                     (!is_red || ((state == CLEAR) && (cnt == CLEAR_LAST)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= STOP;
      light_q     <= LIGHT_RED;
      cnt         <= '0;
      fcnt        <= '0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      flash       <= 1'b0;
      req_pending <= 1'b0;
    end else begin
      light_q <= light;

      // A press coinciding with the grant edge is considered served.
      if (grant)
        req_pending <= 1'b0;
      else if (btn_pulse)
        req_pending <= 1'b1;

      if (to_stop) begin
        state     <= STOP;
        cnt       <= '0;
        walk      <= 1'b0;
        dont_walk <= 1'b1;
        flash     <= 1'b0;
      end else begin
        case (state)
          STOP: begin
            if (grant) begin
              state     <= WALK;
              cnt       <= '0;
              walk      <= 1'b1;
              dont_walk <= 1'b0;
            end
          end
          WALK: begin
            if (walk_done) begin
              state     <= CLEAR;
              cnt       <= '0;
              fcnt      <= '0;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              flash     <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CLEAR: begin
            cnt <= cnt + 1'b1;
            if (fcnt == FDIV_LAST) begin
              fcnt  <= '0;
              flash <= ~flash;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
          default: state <= STOP;
        endcase
      end
    end
  end

`ifdef PED_COUNTDOWN_EN
  logic [3:0] cd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cd_q <= 4'd0;
    else if (walk_done && is_red)
      cd_q <= 4'(CLEAR_CYCLES);
    else if ((state == CLEAR) && !to_stop)
      cd_q <= cd_q - 4'd1;
    else
      cd_q <= 4'd0;
  end

  assign countdown = cd_q;
`else
  assign countdown = 4'd0;
`endif

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Scoreboard bench for ped_signal_ctrl with directed, hand-computed expectations.
module tb_ped_signal_ctrl;

`ifdef PED_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  typedef struct packed {
    logic       w;
    logic       dw;
    logic       f;
    logic [3:0] cd;
    logic       rq;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] light;
  logic       ped_btn;
  logic       walk, dont_walk, flash, req_pending;
  logic [3:0] countdown;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];

  ped_signal_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .light       (light),
    .ped_btn     (ped_btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .flash       (flash),
    .countdown   (countdown),
    .req_pending (req_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [1:0] l, input logic b, input logic w, input logic dw,
                      input logic f, input logic [3:0] cd, input logic rq);
    exp_t e;
    @(negedge clk);
    light   = l;
    ped_btn = b;
    e.w  = w;
    e.dw = dw;
    e.f  = f;
    e.cd = CD_EN ? cd : 4'd0;
    e.rq = rq;
    sb_q.push_back(e);
  endtask

  task automatic stop_steps(input logic [1:0] l, input logic rq, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, rq);
  endtask

  task automatic walk_steps(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Monitor: one output observation per clock, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("walk",        {3'b0, walk},        {3'b0, e.w});
        check("dont_walk",   {3'b0, dont_walk},   {3'b0, e.dw});
        check("flash",       {3'b0, flash},       {3'b0, e.f});
        check("countdown",   countdown,           e.cd);
        check("req_pending", {3'b0, req_pending}, {3'b0, e.rq});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    light   = 2'b00;
    ped_btn = 1'b0;
    #2;
    check("rst_walk",      {3'b0, walk},        4'd0);
    check("rst_dont_walk", {3'b0, dont_walk},   4'd1);
    check("rst_flash",     {3'b0, flash},       4'd0);
    check("rst_countdown", countdown,           4'd0);
    check("rst_req",       {3'b0, req_pending}, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    // Red held from reset: no spurious red entry.
    stop_steps(2'b00, 1'b0, 3);

    // Press during green, then red entry: full WALK and CLEAR.
    step(2'b01, 1'b1, 0, 1, 0, 0, 0);
    step(2'b01, 1'b1, 0, 1, 0, 0, 0);
    step(2'b01, 1'b1, 0, 1, 0, 0, 1);
    step(2'b01, 1'b0, 0, 1, 0, 0, 1);
    walk_steps(6);
    step(2'b00, 1'b0, 0, 1, 1, 4, 0);
    step(2'b00, 1'b0, 0, 1, 0, 3, 0);
    step(2'b00, 1'b0, 0, 1, 1, 2, 0);
    step(2'b00, 1'b0, 0, 1, 0, 1, 0);
    stop_steps(2'b00, 1'b0, 2);

    // Light cycling with no request.
    for (int k = 0; k < 2; k++) begin
      stop_steps(2'b01, 1'b0, 1);
      stop_steps(2'b10, 1'b0, 1);
      stop_steps(2'b00, 1'b0, 1);
    end

    // Abort: light leaves red during the 3rd WALK cycle.
    step(2'b01, 1'b1, 0, 1, 0, 0, 0);
    step(2'b01, 1'b1, 0, 1, 0, 0, 0);
    step(2'b01, 1'b1, 0, 1, 0, 0, 1);
    step(2'b01, 1'b0, 0, 1, 0, 0, 1);
    walk_steps(3);
    stop_steps(2'b01, 1'b0, 2);

    // Press during CLEAR is held and served at the next red entry.
    step(2'b01, 1'b1, 0, 1, 0, 0, 0);
    step(2'b01, 1'b1, 0, 1, 0, 0, 0);
    step(2'b01, 1'b0, 0, 1, 0, 0, 1);
    walk_steps(6);
    step(2'b00, 1'b1, 0, 1, 1, 4, 0);
    step(2'b00, 1'b1, 0, 1, 0, 3, 0);
    step(2'b00, 1'b0, 0, 1, 1, 2, 1);
    step(2'b00, 1'b0, 0, 1, 0, 1, 1);
    stop_steps(2'b00, 1'b1, 1);
    stop_steps(2'b01, 1'b1, 1);
    walk_steps(1);
    stop_steps(2'b01, 1'b0, 1);

    // Illegal light code holds a pending request; 11 -> 00 grants WALK.
    step(2'b11, 1'b1, 0, 1, 0, 0, 0);
    step(2'b11, 1'b1, 0, 1, 0, 0, 0);
    step(2'b11, 1'b0, 0, 1, 0, 0, 1);
    stop_steps(2'b11, 1'b1, 2);
    walk_steps(1);
    step(2'b00, 1'b1, 1, 0, 0, 0, 0);
    step(2'b00, 1'b1, 1, 0, 0, 0, 0);
    step(2'b00, 1'b0, 1, 0, 0, 0, 1);

    // Asynchronous reset mid-WALK with a request pending.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_walk",      {3'b0, walk},        4'd0);
    check("async_dont_walk", {3'b0, dont_walk},   4'd1);
    check("async_req",       {3'b0, req_pending}, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    stop_steps(2'b00, 1'b0, 3);

    @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
